// File: rtl/mul_uint8_rr_arbiter.sv
// Round-robin arbiter that shares one pipelined 8-bit unsigned multiplier
// among NUM_REQ requesters; results come back tagged with the requester ID.
module mul_uint8_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LATENCY = 3,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [8*NUM_REQ-1:0]      req_a,
   input  logic [8*NUM_REQ-1:0]      req_b,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      res_valid,
   output logic [7:0]                res_data,
   output logic [ID_W-1:0]           res_id,
   output logic [ID_W+LATENCY-1:0]   inflight
);

   localparam int unsigned INF_W = ID_W + LATENCY;
   localparam logic [INF_W-1:0] INF_ONE = INF_W'(1);
   localparam logic [ID_W-1:0]  PTR_RST = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    cand;
   logic               found;
   logic [NUM_REQ-1:0] grant;
   logic               accept;
   logic [7:0]         a_sel;
   logic [7:0]         b_sel;
   logic [15:0]        prod;

   logic [LATENCY-1:0] vld;
   logic [7:0]         data_q [LATENCY];
   logic [ID_W-1:0]    id_q   [LATENCY];

   // Search starts one past the last winner and wraps, so the last winner
   // becomes the lowest priority.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      grant  = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      if (found && !rst) begin
         grant[winner] = 1'b1;
      end
   end

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);

   always_comb begin
      a_sel = req_a[8*winner +: 8];
      b_sel = req_b[8*winner +: 8];
      prod  = 16'(a_sel) * 16'(b_sel);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= PTR_RST;
      end else if (accept) begin
         rr_ptr <= winner;
      end
   end

   // Valid bits shift every cycle; payload only moves behind a valid bit so
   // the output payload holds its last value across bubbles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int unsigned k = 0; k < LATENCY; k++) begin
            data_q[k] <= '0;
            id_q[k]   <= '0;
         end
      end else begin
         vld[0] <= accept;
         if (accept) begin
            data_q[0] <= prod[7:0];
            id_q[0]   <= winner;
         end
         for (int unsigned k = 1; k < LATENCY; k++) begin
            vld[k] <= vld[k-1];
            if (vld[k-1]) begin
               data_q[k] <= data_q[k-1];
               id_q[k]   <= id_q[k-1];
            end
         end
      end
   end

   assign res_valid = vld[LATENCY-1];
   assign res_data  = data_q[LATENCY-1];
   assign res_id    = id_q[LATENCY-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         case ({accept, res_valid})
            2'b10:   inflight <= inflight + INF_ONE;
            2'b01:   inflight <= inflight - INF_ONE;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_uint8_rr_arbiter.sv
// Directed and random stimulus for mul_uint8_rr_arbiter, checked against a
// queue-based reference model of arbitration order and result timing.
module tb_mul_uint8_rr_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned LATENCY = 3;
   localparam int unsigned ID_W    = $clog2(NUM_REQ);

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NUM_REQ-1:0]      req_valid;
   logic [8*NUM_REQ-1:0]    req_a;
   logic [8*NUM_REQ-1:0]    req_b;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    res_valid;
   logic [7:0]              res_data;
   logic [ID_W-1:0]         res_id;
   logic [ID_W+LATENCY-1:0] inflight;

   mul_uint8_rr_arbiter #(
      .NUM_REQ(NUM_REQ),
      .LATENCY(LATENCY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_ready(req_ready),
      .res_valid(res_valid),
      .res_data (res_data),
      .res_id   (res_id),
      .inflight (inflight)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       due;
      int       data;
      int       id;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   m_ptr = NUM_REQ - 1;
   int   last_grant;
   logic [NUM_REQ-1:0] last_ready;
   logic               last_res_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      req_valid[i]     = 1'b1;
      req_a[8*i +: 8]  = a;
      req_b[8*i +: 8]  = b;
   endtask

   // One cycle: compare outputs with the model at the falling edge, then
   // advance the model by whatever was accepted this cycle.
   task automatic step();
      int   w;
      exp_t e;
      @(negedge clk);
      last_ready     = req_ready;
      last_res_valid = res_valid;
      chk("inflight", 32'(inflight), 32'(exp_q.size()));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("res_valid", 32'(res_valid), 32'd1);
         chk("res_data", 32'(res_data), 32'(exp_q[0].data));
         chk("res_id", 32'(res_id), 32'(exp_q[0].id));
         void'(exp_q.pop_front());
      end else begin
         chk("res_valid_idle", 32'(res_valid), 32'd0);
      end
      w = -1;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         int i;
         i = (m_ptr + k) % int'(NUM_REQ);
         if (w < 0 && req_valid[i]) w = i;
      end
      if (w >= 0) begin
         chk("req_ready", 32'(req_ready), 32'(1) << w);
         e.due  = cyc + int'(LATENCY);
         e.data = (int'(req_a[8*w +: 8]) * int'(req_b[8*w +: 8])) % 256;
         e.id   = w;
         exp_q.push_back(e);
         m_ptr  = w;
      end else begin
         chk("req_ready_zero", 32'(req_ready), 32'd0);
      end
      last_grant = w;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      req_valid = '0;
      repeat (LATENCY + 1) step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NUM_REQ-1:0] wrap_exp [4];
      rst       = 1'b1;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_inflight", 32'(inflight), 32'd0);
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // All requesters valid and held: grants rotate from requester 0.
      for (int i = 0; i < int'(NUM_REQ); i++) set_req(i, 8'(i + 1), 8'd10);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("rot_grant", 32'(last_ready), 32'(1) << (k % int'(NUM_REQ)));
      end
      drain();

      // Single request 3*7.
      set_req(0, 8'd3, 8'd7);
      step();
      chk("single_grant", 32'(last_ready), 32'd1);
      drain();

      // Fairness wrap: move pointer to 2, then hold requests 0,1,3.
      set_req(2, 8'd5, 8'd6);
      step();
      req_valid = '0;
      set_req(0, 8'd11, 8'd12);
      set_req(1, 8'd13, 8'd14);
      set_req(3, 8'd15, 8'd16);
      wrap_exp[0] = 4'b1000;
      wrap_exp[1] = 4'b0001;
      wrap_exp[2] = 4'b0010;
      wrap_exp[3] = 4'b1000;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("wrap_grant", 32'(last_ready), 32'(wrap_exp[k]));
      end
      drain();

      // Overflow cases, back to back from one requester.
      set_req(1, 8'd255, 8'd255);
      step();
      set_req(1, 8'd16, 8'd16);
      step();
      set_req(1, 8'd0, 8'd200);
      step();
      req_valid = '0;
      repeat (LATENCY - 1) step();
      @(negedge clk);
      chk("ovf_last_valid", 32'(res_valid), 32'd1);
      chk("ovf_last_data", 32'(res_data), 32'd0);
      @(posedge clk);
      #1;
      void'(exp_q.pop_front());
      cyc++;
      drain();

      // Reset between edges with two operations in flight.
      set_req(0, 8'd9, 8'd9);
      set_req(1, 8'd7, 8'd7);
      step();
      step();
      req_valid = '0;
      step();
      #2;
      rst = 1'b1;
      req_valid = '1;
      #1;
      chk("midrst_res_valid", 32'(res_valid), 32'd0);
      chk("midrst_inflight", 32'(inflight), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      exp_q.delete();
      m_ptr = NUM_REQ - 1;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      repeat (LATENCY + 2) step();
      set_req(2, 8'd4, 8'd4);
      set_req(0, 8'd2, 8'd2);
      step();
      chk("post_rst_grant", 32'(last_ready), 32'd1);
      drain();

      // Idle gaps: requests at relative cycles 0, 2 and 5.
      for (int c = 0; c <= 5 + int'(LATENCY) + 1; c++) begin
         req_valid = '0;
         if (c == 0 || c == 2 || c == 5) set_req(3, 8'($urandom), 8'($urandom));
         step();
         chk("gap_valid", 32'(last_res_valid),
             32'((c == int'(LATENCY)) || (c == 2 + int'(LATENCY)) || (c == 5 + int'(LATENCY))));
      end

      // Random traffic; pending requests stay valid until accepted.
      req_valid = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!req_valid[i] && ($urandom_range(0, 2) != 0))
               set_req(i, 8'($urandom), 8'($urandom));
         end
         step();
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
